mem_access_unit: RTL and testbench

- MEM-stage data-memory access unit, between the EX/M pipeline register and the M/WB pipeline register.
- Drives a req/ack data-memory bus and generates little-endian byte enables and store lane steering.
- Extracts and sign/zero-extends load data and stalls the pipeline until the access completes.
- Its outputs feed M/WB directly: M_DM_Read_Data, M_WD_out, M_WR_out, M_MemtoReg_out, M_RegWrite_out.

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage access unit: size codes, FSM encoding,
// default bus timeout and the alignment rule.
package mips_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_DEF = 64;

  // Size code 2'b11 falls into the word rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = lo[0];
      default:  misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane logic: byte enables plus either store replication (load=0)
// or load select and sign/zero extension (load=1).
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic        load,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  lo,
  input  logic [31:0] din,
  output logic [3:0]  be,
  output logic [31:0] dout
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    case (lo)
      2'd0:    sel_b = din[7:0];
      2'd1:    sel_b = din[15:8];
      2'd2:    sel_b = din[23:16];
      default: sel_b = din[31:24];
    endcase
    sel_h = lo[1] ? din[31:16] : din[15:0];
  end

  always_comb begin
    be   = 4'b1111;
    dout = din;
    case (size)
      MEM_BYTE: begin
        be   = 4'b0001 << lo;
        dout = load ? {{24{sgn & sel_b[7]}}, sel_b} : {4{din[7:0]}};
      end
      MEM_HALF: begin
        be   = lo[1] ? 4'b1100 : 4'b0011;
        dout = load ? {{16{sgn & sel_h[15]}}, sel_h} : {2{din[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus master with lane steering and stall.
// Define MEM_TIMEOUT_EN to abort a request after TIMEOUT unacknowledged REQ cycles.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned data_size = 32,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 M_MemRead,
  input  logic                 M_MemWrite,
  input  logic [1:0]           M_MemSize,
  input  logic                 M_MemSigned,
  input  logic [data_size-1:0] M_ALU_result,
  input  logic [data_size-1:0] M_Write_Data,
  input  logic [4:0]           M_WR,
  input  logic                 M_MemtoReg,
  input  logic                 M_RegWrite,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [data_size-1:0] dm_addr,
  output logic [data_size-1:0] dm_wdata,
  output logic [3:0]           dm_be,
  input  logic                 dm_ack,
  input  logic [data_size-1:0] dm_rdata,
  output logic [data_size-1:0] M_DM_Read_Data,
  output logic [data_size-1:0] M_WD_out,
  output logic [4:0]           M_WR_out,
  output logic                 M_MemtoReg_out,
  output logic                 M_RegWrite_out,
  output logic                 mem_stall,
  output logic                 M_misalign,
  output logic                 M_bus_err
);

  state_e state_q, state_d;

  logic                 mem_op, mis, start, timeout, bus_err;
  logic [data_size-1:0] addr_q, wdata_q, rdata_q;
  logic                 we_q, sgn_q;
  logic [3:0]           be_q;
  logic [1:0]           size_q, lo_q;
  logic [3:0]           st_be, unused_ld_be;
  logic [31:0]          st_wdata, ld_data;

  assign mem_op = M_MemRead | M_MemWrite;
  assign mis    = misaligned(M_MemSize, M_ALU_result[1:0]);
  assign start  = (state_q == S_IDLE) && mem_op && !mis;

  mem_lane_align u_store (
    .load (1'b0),
    .size (M_MemSize),
    .sgn  (M_MemSigned),
    .lo   (M_ALU_result[1:0]),
    .din  (M_Write_Data),
    .be   (st_be),
    .dout (st_wdata)
  );

  // Load formatting uses the attributes captured at request time.
  mem_lane_align u_load (
    .load (1'b1),
    .size (size_q),
    .sgn  (sgn_q),
    .lo   (lo_q),
    .din  (dm_rdata),
    .be   (unused_ld_be),
    .dout (ld_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;
  logic            bus_err_q;

  // An ack on the timeout edge wins, hence the !dm_ack term.
  assign timeout = (state_q == S_REQ) && !dm_ack && (cnt_q == CntW'(TIMEOUT - 1));
  assign bus_err = (state_q == S_DONE) && bus_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (start) begin
        cnt_q <= '0;
      end else if (state_q == S_REQ && !dm_ack) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (state_q == S_REQ) begin
        bus_err_q <= timeout;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timeout        = 1'b0;
  assign bus_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   if (dm_ack || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dm_req     = 1'b0;
    mem_stall  = 1'b0;
    M_misalign = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_stall  = start;
        M_misalign = mem_op & mis;
      end
      S_REQ: begin
        dm_req    = 1'b1;
        mem_stall = 1'b1;
      end
      default: ;
    endcase
    if (!rst) begin
      mem_stall  = 1'b0;
      M_misalign = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (start) begin
        addr_q  <= {M_ALU_result[data_size-1:2], 2'b00};
        we_q    <= M_MemWrite;
        wdata_q <= st_wdata;
        be_q    <= st_be;
        size_q  <= M_MemSize;
        sgn_q   <= M_MemSigned;
        lo_q    <= M_ALU_result[1:0];
      end
      if (state_q == S_REQ) begin
        if (dm_ack) begin
          if (!we_q) rdata_q <= ld_data;
        end else if (timeout) begin
          rdata_q <= '0;
        end
      end
    end
  end

  assign dm_we          = we_q;
  assign dm_addr        = addr_q;
  assign dm_wdata       = wdata_q;
  assign dm_be          = be_q;
  assign M_DM_Read_Data = rdata_q;
  assign M_WD_out       = M_ALU_result;
  assign M_WR_out       = M_WR;
  assign M_MemtoReg_out = M_MemtoReg;
  assign M_RegWrite_out = M_RegWrite & ~M_misalign & ~bus_err;
  assign M_bus_err      = bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand sequences
// and randomized transactions against a byte-arithmetic reference model.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        M_MemRead, M_MemWrite, M_MemSigned, M_MemtoReg, M_RegWrite;
  logic [1:0]  M_MemSize;
  logic [31:0] M_ALU_result, M_Write_Data;
  logic [4:0]  M_WR;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic [31:0] M_DM_Read_Data, M_WD_out;
  logic [4:0]  M_WR_out;
  logic        M_MemtoReg_out, M_RegWrite_out, mem_stall, M_misalign, M_bus_err;

  always #5 clk = ~clk;

  mem_access_unit #(.data_size(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_MemSize(M_MemSize),
    .M_MemSigned(M_MemSigned), .M_ALU_result(M_ALU_result), .M_Write_Data(M_Write_Data),
    .M_WR(M_WR), .M_MemtoReg(M_MemtoReg), .M_RegWrite(M_RegWrite),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .M_DM_Read_Data(M_DM_Read_Data), .M_WD_out(M_WD_out), .M_WR_out(M_WR_out),
    .M_MemtoReg_out(M_MemtoReg_out), .M_RegWrite_out(M_RegWrite_out),
    .mem_stall(mem_stall), .M_misalign(M_misalign), .M_bus_err(M_bus_err)
  );

  int checks = 0;
  int errors = 0;
  int stall_hist[$];
  logic [31:0] last_load;

  int          r_nreq, r_nstall;
  logic [31:0] r_addr, r_wdata, r_data, r_wd_out;
  logic [3:0]  r_be;
  logic [4:0]  r_wr;
  logic        r_we, r_mis, r_rw, r_err, r_unstable, r_mtr;

  typedef struct {
    logic rd; logic wr; logic [1:0] size; logic sgn;
    logic [31:0] addr; logic [31:0] wd; logic [31:0] rdat; int ack;
    logic mis; logic [3:0] be; logic [31:0] wdata; logic [31:0] data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    M_MemRead = 0; M_MemWrite = 0; dm_ack = 0;
  endtask

  // One MEM-stage instruction; samples every falling edge until the stall releases.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                        input int ack_after, input logic [4:0] wreg, input logic mtr,
                        input logic regw);
    int cyc;
    bit done;
    @(posedge clk); #1;
    M_MemRead = rd; M_MemWrite = wr; M_MemSize = size; M_MemSigned = sgn;
    M_ALU_result = addr; M_Write_Data = wd; M_WR = wreg; M_MemtoReg = mtr;
    M_RegWrite = regw; dm_ack = 0;
    r_nreq = 0; r_nstall = 0; r_unstable = 0; r_err = 0; done = 0; cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      stall_hist.push_back(int'(mem_stall));
      if (cyc == 1) begin
        r_mis = M_misalign; r_wd_out = M_WD_out; r_wr = M_WR_out;
        r_mtr = M_MemtoReg_out; r_rw = M_RegWrite_out;
      end
      if (mem_stall) r_nstall++;
      if (dm_req) begin
        r_nreq++;
        if (r_nreq == 1) begin
          r_addr = dm_addr; r_we = dm_we; r_be = dm_be; r_wdata = dm_wdata;
        end else if (dm_addr !== r_addr || dm_we !== r_we || dm_be !== r_be ||
                     dm_wdata !== r_wdata) begin
          r_unstable = 1;
        end
        dm_ack   = (r_nreq == ack_after);
        dm_rdata = dm_ack ? rdat : $urandom();
      end else begin
        // Stray acks outside REQ must be ignored.
        dm_ack   = 1'b1;
        dm_rdata = $urandom();
        if (!mem_stall) begin
          done   = 1;
          r_data = M_DM_Read_Data;
          r_err  = M_bus_err;
          if (r_nreq > 0) r_rw = M_RegWrite_out;
        end
      end
    end
    if (!done) chk("txn_bound", 32'd0, 32'd1);
  endtask

  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes_of(size)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int n = nbytes_of(size);
    int off = (addr % 4) / n * n;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    int n = nbytes_of(size);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    logic [31:0] w = 0;
    for (int k = 0; k < 4; k += n) w |= (wd & mask) << (8 * k);
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] addr, input logic [31:0] rdat);
    int n = nbytes_of(size);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    logic [31:0] v = (rdat >> (8 * (addr % 4))) & mask;
    if (sgn && n < 4 && v[8 * n - 1]) v |= ~mask;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t tv[12];
    int   exp_pat[6];
    logic rd, regw, sgn, mtr;
    logic [1:0] size;
    logic [31:0] addr, wd, rdat;
    logic [4:0] wreg;
    int ack;

    M_MemRead = 1; M_MemWrite = 0; M_MemSize = MEM_WORD; M_MemSigned = 0;
    M_ALU_result = 32'h100; M_Write_Data = 0; M_WR = 0; M_MemtoReg = 0; M_RegWrite = 1;
    dm_ack = 0; dm_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", dm_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_be", dm_be, 0);
    chk("rst_rdata", M_DM_Read_Data, 0);
    chk("rst_bus_err", M_bus_err, 0);
    M_MemRead = 0;
    rst = 1;
    last_load = 0;

    tv[0]  = '{1, 0, 2'b10, 0, 32'h100, 32'h0,        32'h89ABCDEF, 3, 0, 4'hF, 32'h0,        32'h89ABCDEF};
    tv[1]  = '{1, 0, 2'b00, 1, 32'h103, 32'h0,        32'h80FF7F01, 1, 0, 4'h8, 32'h0,        32'hFFFFFF80};
    tv[2]  = '{1, 0, 2'b00, 0, 32'h103, 32'h0,        32'h80FF7F01, 2, 0, 4'h8, 32'h0,        32'h00000080};
    tv[3]  = '{0, 1, 2'b01, 0, 32'h022, 32'h0000BEEF, 32'h0,        1, 0, 4'hC, 32'hBEEFBEEF, 32'h00000080};
    tv[4]  = '{0, 1, 2'b00, 0, 32'h021, 32'h000000A5, 32'h0,        1, 0, 4'h2, 32'hA5A5A5A5, 32'h00000080};
    tv[5]  = '{1, 0, 2'b10, 0, 32'h102, 32'h0,        32'h0,        1, 1, 4'h0, 32'h0,        32'h0};
    tv[6]  = '{1, 0, 2'b01, 1, 32'h102, 32'h0,        32'h80017FFF, 1, 0, 4'hC, 32'h0,        32'hFFFF8001};
    tv[7]  = '{1, 0, 2'b01, 0, 32'h100, 32'h0,        32'h8001F00D, 2, 0, 4'h3, 32'h0,        32'h0000F00D};
    tv[8]  = '{1, 0, 2'b01, 1, 32'h101, 32'h0,        32'h0,        1, 1, 4'h0, 32'h0,        32'h0};
    tv[9]  = '{1, 0, 2'b00, 1, 32'h101, 32'h0,        32'h00007F00, 1, 0, 4'h2, 32'h0,        32'h0000007F};
    tv[10] = '{0, 1, 2'b10, 0, 32'h000, 32'h12345678, 32'h0,        1, 0, 4'hF, 32'h12345678, 32'h0000007F};
    tv[11] = '{1, 0, 2'b11, 1, 32'h104, 32'h0,        32'hCAFEBABE, 1, 0, 4'hF, 32'h0,        32'hCAFEBABE};

    foreach (tv[i]) begin
      run_op(tv[i].rd, tv[i].wr, tv[i].size, tv[i].sgn, tv[i].addr, tv[i].wd, tv[i].rdat,
             tv[i].ack, 5'd3, 1'b1, 1'b1);
      if (tv[i].mis) begin
        chk($sformatf("v%0d_misalign", i), r_mis, 1);
        chk($sformatf("v%0d_nreq", i), r_nreq, 0);
        chk($sformatf("v%0d_nstall", i), r_nstall, 0);
        chk($sformatf("v%0d_regwrite", i), r_rw, 0);
      end else begin
        chk($sformatf("v%0d_nreq", i), r_nreq, tv[i].ack);
        chk($sformatf("v%0d_nstall", i), r_nstall, tv[i].ack + 1);
        chk($sformatf("v%0d_addr", i), r_addr, {tv[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_we", i), r_we, tv[i].wr);
        chk($sformatf("v%0d_be", i), r_be, tv[i].be);
        if (tv[i].wr) chk($sformatf("v%0d_wdata", i), r_wdata, tv[i].wdata);
        chk($sformatf("v%0d_data", i), r_data, tv[i].data);
        chk($sformatf("v%0d_stable", i), r_unstable, 0);
        chk($sformatf("v%0d_regwrite", i), r_rw, 1);
      end
    end
    last_load = 32'hCAFEBABE;

    // Back-to-back load then store, each acked in its first REQ cycle.
    stall_hist.delete();
    run_op(1, 0, MEM_WORD, 0, 32'h200, 32'h0, 32'h11223344, 1, 5'd4, 1'b1, 1'b1);
    chk("b2b_load_data", r_data, 32'h11223344);
    run_op(0, 1, MEM_BYTE, 0, 32'h203, 32'h5A, 32'h0, 1, 5'd0, 1'b0, 1'b0);
    chk("b2b_store_be", r_be, 4'b1000);
    last_load = 32'h11223344;
    exp_pat = '{1, 1, 0, 1, 1, 0};
    chk("b2b_len", stall_hist.size(), 6);
    for (int i = 0; i < 6 && i < stall_hist.size(); i++)
      chk($sformatf("b2b_stall%0d", i), stall_hist[i], exp_pat[i]);

    // Acks with no request pending leave the unit idle and the read data intact.
    go_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dm_ack = 1; dm_rdata = $urandom();
    end
    @(negedge clk);
    dm_ack = 0;
    chk("stray_ack_req", dm_req, 0);
    chk("stray_ack_data", M_DM_Read_Data, last_load);

    // Reset asserted while a store is in REQ.
    @(posedge clk); #1;
    M_MemWrite = 1; M_MemRead = 0; M_MemSize = MEM_WORD; M_ALU_result = 32'h300;
    M_Write_Data = 32'hDEADBEEF; dm_ack = 0;
    @(posedge clk); #2;
    chk("midrst_pre_req", dm_req, 1);
    rst = 0; dm_ack = 1; dm_rdata = 32'h55AA55AA;
    #1;
    chk("midrst_req", dm_req, 0);
    chk("midrst_stall", mem_stall, 0);
    chk("midrst_we", dm_we, 0);
    chk("midrst_addr", dm_addr, 0);
    chk("midrst_wdata", dm_wdata, 0);
    chk("midrst_be", dm_be, 0);
    chk("midrst_rdata", M_DM_Read_Data, 0);
    chk("midrst_misalign", M_misalign, 0);
    @(posedge clk);
    @(negedge clk);
    M_MemWrite = 0; dm_ack = 0; rst = 1;
    @(negedge clk);
    chk("postrst_req", dm_req, 0);
    chk("postrst_rdata", M_DM_Read_Data, 0);
    last_load = 0;

`ifdef MEM_TIMEOUT_EN
    run_op(1, 0, MEM_WORD, 0, 32'h400, 32'h0, 32'h0, 0, 5'd7, 1'b1, 1'b1);
    chk("to_nreq", r_nreq, TO);
    chk("to_nstall", r_nstall, TO + 1);
    chk("to_bus_err", r_err, 1);
    chk("to_regwrite", r_rw, 0);
    chk("to_data", r_data, 0);
    last_load = 0;
`endif

    for (int n = 0; n < 60; n++) begin
      rd   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      sgn  = 1'($urandom_range(0, 1));
      addr = $urandom();
      wd   = $urandom();
      rdat = $urandom();
      ack  = $urandom_range(1, 4);
      wreg = 5'($urandom());
      mtr  = 1'($urandom_range(0, 1));
      regw = 1'($urandom_range(0, 1));
      run_op(rd, !rd, size, sgn, addr, wd, rdat, ack, wreg, mtr, regw);
      chk("rnd_wd_out", r_wd_out, addr);
      chk("rnd_wr_out", r_wr, wreg);
      chk("rnd_mtr_out", r_mtr, mtr);
      chk("rnd_misalign", r_mis, m_mis(size, addr));
      if (m_mis(size, addr)) begin
        chk("rnd_mis_nreq", r_nreq, 0);
        chk("rnd_mis_regwrite", r_rw, 0);
      end else begin
        chk("rnd_nreq", r_nreq, ack);
        chk("rnd_nstall", r_nstall, ack + 1);
        chk("rnd_addr", r_addr, addr & 32'hFFFF_FFFC);
        chk("rnd_we", r_we, !rd);
        chk("rnd_be", r_be, m_be(size, addr));
        if (!rd) chk("rnd_wdata", r_wdata, m_wdata(size, wd));
        if (rd) last_load = m_load(size, sgn, addr, rdat);
        chk("rnd_data", r_data, last_load);
        chk("rnd_regwrite", r_rw, regw);
        chk("rnd_bus_err", r_err, 0);
        chk("rnd_stable", r_unstable, 0);
      end
    end
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
